serdes_deser_align: RTL and testbench

Parametrised serial-to-parallel receiver for the serdes path. It takes one serial bit per `clk` and locates word boundaries by searching for a comma (control) character. After a configurable number of aligned commas it declares lock and emits BITS-wide words with a valid strobe and a data/control (`out_DK`) flag. It sits directly after the serial link and feeds the parallel register/decoder stage.

---
 rtl/serdes_deser_align.sv | 216 +++++++++++++++++++++
 tb/tb_serdes_deser_align.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serdes_deser_align.sv
// ---------------------------------------------------------------------------
// serdes_deser_align
//
// Serial-to-parallel receiver with comma-based word alignment. One serial
// bit is shifted in per clock, MSB of each word first. The receiver hunts
// for the COMMA pattern and uses it to set the word phase. It then needs
// LOCK_CNT consecutive commas on word boundaries before it declares lock.
// While locked it emits one BITS-wide word per BITS cycles. UNLOCK_CNT
// commas seen off the word boundary drop the lock and restart the hunt.
//
// Parameters:
//   BITS        word width (>= 4)
//   COMMA       comma/control pattern, BITS wide
//   LOCK_CNT    consecutive aligned commas needed to lock (>= 1)
//   UNLOCK_CNT  misaligned commas, counted while locked, that drop lock (>= 1)
//
// Ports:
//   clk      in   single clock, all state on the rising edge
//   reset_L  in   asynchronous active-low reset
//   data     in   serial input bit
//   out      out  aligned parallel word (holds between strobes)
//   out_DK   out  1 = out is the comma (control), 0 = data
//   valid    out  one-cycle strobe per emitted word
//   lock     out  alignment locked
//   err_cnt  out  saturating count of misaligned commas seen while locked
//
// Optional feature macro:
//   DESER_ERRCNT_EN  when defined, err_cnt counts misaligned commas, saturates
//                    at 255 and clears only on reset. When undefined, err_cnt
//                    is tied to zero.
// ---------------------------------------------------------------------------
module serdes_deser_align #(
    parameter int              BITS       = 8,
    parameter logic [BITS-1:0] COMMA      = 8'hBC,
    parameter int              LOCK_CNT   = 3,
    parameter int              UNLOCK_CNT = 2
) (
    input  logic            clk,
    input  logic            reset_L,
    input  logic            data,
    output logic [BITS-1:0] out,
    output logic            out_DK,
    output logic            valid,
    output logic            lock,
    output logic [7:0]      err_cnt
);

    localparam int PH_W    = $clog2(BITS);
    localparam int MATCH_W = $clog2(LOCK_CNT + 1);
    localparam int MISS_W  = $clog2(UNLOCK_CNT + 1);

    localparam logic [PH_W-1:0]    PH_LAST    = PH_W'(BITS - 1);
    localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_CNT - 1);
    localparam logic [MISS_W-1:0]  MISS_LAST  = MISS_W'(UNLOCK_CNT - 1);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t              state;
    state_t              next_state;
    logic [BITS-1:0]     sr;
    logic [PH_W-1:0]     ph;
    logic [MATCH_W-1:0]  match_cnt;
    logic [MISS_W-1:0]   miss_cnt;

    logic is_comma;
    logic boundary;
    logic ph_clear;
    logic match_load;
    logic match_inc;
    logic match_clr;
    logic miss_evt;
    logic miss_clr;
    logic emit;

    // The window is the registered shift register itself, so every output
    // below is derived from flops and never from the live serial input.
    assign is_comma = (sr == COMMA);
    assign boundary = (ph == PH_LAST);

    // State register.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state <= HUNT;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and control decode. A comma on a boundary cycle is always
    // treated as aligned, so it can never also count as a miss.
    always_comb begin
        next_state = state;
        ph_clear   = 1'b0;
        match_load = 1'b0;
        match_inc  = 1'b0;
        match_clr  = 1'b0;
        miss_evt   = 1'b0;
        miss_clr   = 1'b0;
        emit       = 1'b0;
        case (state)
            HUNT: begin
                if (is_comma) begin
                    // The comma defines the word phase: this cycle is a
                    // boundary, so the next word completes BITS cycles on.
                    ph_clear   = 1'b1;
                    match_load = 1'b1;
                    if (LOCK_CNT == 1) begin
                        next_state = LOCKED;
                        emit       = 1'b1;
                        miss_clr   = 1'b1;
                    end else begin
                        next_state = SYNC;
                    end
                end
            end
            SYNC: begin
                if (boundary) begin
                    if (is_comma) begin
                        if (match_cnt == MATCH_LAST) begin
                            next_state = LOCKED;
                            emit       = 1'b1;
                            miss_clr   = 1'b1;
                            match_clr  = 1'b1;
                        end else begin
                            match_inc = 1'b1;
                        end
                    end else begin
                        next_state = HUNT;
                        match_clr  = 1'b1;
                    end
                end
            end
            LOCKED: begin
                if (boundary) begin
                    emit = 1'b1;
                    if (is_comma) begin
                        miss_clr = 1'b1;
                    end
                end else if (is_comma) begin
                    miss_evt = 1'b1;
                    if (miss_cnt == MISS_LAST) begin
                        next_state = HUNT;
                        miss_clr   = 1'b1;
                    end
                end
            end
            default: begin
                next_state = HUNT;
            end
        endcase
    end

    // Shift register, phase counter, alignment counters and registered
    // outputs. lock follows the next state so it rises with the first
    // strobe and falls on the edge that leaves LOCKED.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            sr        <= '0;
            ph        <= '0;
            match_cnt <= '0;
            miss_cnt  <= '0;
            out       <= '0;
            out_DK    <= 1'b0;
            valid     <= 1'b0;
            lock      <= 1'b0;
        end else begin
            sr <= {sr[BITS-2:0], data};

            if (ph_clear || boundary) begin
                ph <= '0;
            end else begin
                ph <= ph + PH_W'(1);
            end

            if (match_clr) begin
                match_cnt <= '0;
            end else if (match_load) begin
                match_cnt <= MATCH_W'(1);
            end else if (match_inc) begin
                match_cnt <= match_cnt + MATCH_W'(1);
            end

            if (miss_clr) begin
                miss_cnt <= '0;
            end else if (miss_evt) begin
                miss_cnt <= miss_cnt + MISS_W'(1);
            end

            valid <= emit;
            if (emit) begin
                out    <= sr;
                out_DK <= is_comma;
            end

            lock <= (next_state == LOCKED);
        end
    end

`ifdef DESER_ERRCNT_EN
    // Saturating misaligned-comma counter; survives loss of lock and relock.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            err_cnt <= 8'd0;
        end else if (miss_evt && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end
`else
    assign err_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_serdes_deser_align.sv
// ---------------------------------------------------------------------------
// tb_serdes_deser_align
//
// Directed bench for serdes_deser_align with BITS=8, COMMA=8'hBC,
// LOCK_CNT=3, UNLOCK_CNT=2. Serial words are shifted in MSB first, and the
// expected values are worked out by hand from the word grid. The err_cnt
// expectations depend on whether DESER_ERRCNT_EN is defined.
// ---------------------------------------------------------------------------
module tb_serdes_deser_align;

    localparam logic [7:0] BC  = 8'hBC;
    localparam logic [7:0] D55 = 8'h55;
    localparam logic [7:0] D00 = 8'h00;

`ifdef DESER_ERRCNT_EN
    localparam logic [7:0] ERR1 = 8'd1;
    localparam logic [7:0] ERR2 = 8'd2;
`else
    localparam logic [7:0] ERR1 = 8'd0;
    localparam logic [7:0] ERR2 = 8'd0;
`endif

    logic       clk = 1'b0;
    logic       reset_L = 1'b0;
    logic       data = 1'b0;
    logic [7:0] out;
    logic       out_DK;
    logic       valid;
    logic       lock;
    logic [7:0] err_cnt;

    int         errors = 0;
    int         checks = 0;
    int         vcount = 0;
    logic [7:0] last_out = 8'h00;
    logic       last_dk = 1'b0;

    serdes_deser_align #(
        .BITS       (8),
        .COMMA      (8'hBC),
        .LOCK_CNT   (3),
        .UNLOCK_CNT (2)
    ) dut (
        .clk     (clk),
        .reset_L (reset_L),
        .data    (data),
        .out     (out),
        .out_DK  (out_DK),
        .valid   (valid),
        .lock    (lock),
        .err_cnt (err_cnt)
    );

    always #5 clk = ~clk;

    // Drive one bit, let the edge take it, then sample 1 time unit later
    // and record any strobe that edge produced.
    task automatic send_bit(input logic b);
        data = b;
        @(posedge clk);
        #1;
        if (valid) begin
            vcount++;
            last_out = out;
            last_dk  = out_DK;
        end
    endtask

    task automatic send_bits(input logic [7:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            send_bit(v[i]);
        end
    endtask

    task automatic send_word(input logic [7:0] w);
        send_bits(w, 8);
    endtask

    task automatic do_reset();
        data    = 1'b0;
        reset_L = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_L = 1'b1;
        vcount  = 0;
    endtask

    task automatic test_reset();
        reset_L = 1'b0;
        for (int c = 0; c < 20; c++) begin
            data = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            checks++;
            if (out !== 8'h00) begin
                errors++;
                $display("[TB] FAIL reset_out cycle %0d: out=%h expected 00", c, out);
            end
            checks++;
            if (out_DK !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_dk cycle %0d: out_DK=%b expected 0", c, out_DK);
            end
            checks++;
            if (valid !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_valid cycle %0d: valid=%b expected 0", c, valid);
            end
            checks++;
            if (lock !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_lock cycle %0d: lock=%b expected 0", c, lock);
            end
            checks++;
            if (err_cnt !== 8'h00) begin
                errors++;
                $display("[TB] FAIL reset_err cycle %0d: err_cnt=%h expected 00", c, err_cnt);
            end
        end
        reset_L = 1'b1;
        data    = 1'b0;
    endtask

    task automatic test_lock();
        do_reset();
        send_bits(8'h05, 3);
        send_word(BC);
        send_word(BC);
        send_word(BC);
        checks++;
        if (vcount !== 0 || lock !== 1'b0) begin
            errors++;
            $display("[TB] FAIL lock_early: strobes=%0d lock=%b expected 0 and 0", vcount, lock);
        end
        send_bit(1'b0);
        checks++;
        if (valid !== 1'b1 || lock !== 1'b1) begin
            errors++;
            $display("[TB] FAIL lock_rise: valid=%b lock=%b expected 1 and 1", valid, lock);
        end
        checks++;
        if (out !== BC || out_DK !== 1'b1) begin
            errors++;
            $display("[TB] FAIL lock_comma: out=%h out_DK=%b expected bc and 1", out, out_DK);
        end
        vcount = 0;
        send_bits(D55, 7);
        checks++;
        if (vcount !== 0) begin
            errors++;
            $display("[TB] FAIL lock_gap: strobes=%0d expected 0", vcount);
        end
        checks++;
        if (out !== BC || out_DK !== 1'b1) begin
            errors++;
            $display("[TB] FAIL lock_hold: out=%h out_DK=%b expected bc and 1", out, out_DK);
        end
        send_bit(1'b0);
        checks++;
        if (valid !== 1'b1 || out !== D55 || out_DK !== 1'b0) begin
            errors++;
            $display("[TB] FAIL lock_data: valid=%b out=%h out_DK=%b expected 1 55 0", valid, out, out_DK);
        end
    endtask

    // Continues from the locked state left by test_lock.
    task automatic test_back_to_back();
        vcount = 0;
        send_bits(D00, 7);
        send_word(D55);
        send_word(D00);
        send_bit(1'b0);
        checks++;
        if (vcount !== 3) begin
            errors++;
            $display("[TB] FAIL b2b_count: strobes=%0d expected 3", vcount);
        end
        checks++;
        if (valid !== 1'b1 || last_out !== D00 || last_dk !== 1'b0 || lock !== 1'b1) begin
            errors++;
            $display("[TB] FAIL b2b_last: valid=%b out=%h dk=%b lock=%b expected 1 00 0 1",
                     valid, last_out, last_dk, lock);
        end
    endtask

    task automatic test_sync_fail();
        do_reset();
        send_word(BC);
        send_word(D55);
        send_word(D55);
        checks++;
        if (vcount !== 0 || lock !== 1'b0) begin
            errors++;
            $display("[TB] FAIL sync_fail: strobes=%0d lock=%b expected 0 and 0", vcount, lock);
        end
        send_word(BC);
        send_word(BC);
        send_word(BC);
        checks++;
        if (vcount !== 0) begin
            errors++;
            $display("[TB] FAIL sync_early: strobes=%0d expected 0", vcount);
        end
        send_bit(1'b0);
        checks++;
        if (lock !== 1'b1 || valid !== 1'b1 || out !== BC) begin
            errors++;
            $display("[TB] FAIL sync_relock: lock=%b valid=%b out=%h expected 1 1 bc", lock, valid, out);
        end
    endtask

    task automatic test_loss_of_lock();
        do_reset();
        send_word(BC);
        send_word(BC);
        send_word(BC);
        send_word(D55);
        send_bits(8'h00, 3);
        send_word(BC);
        send_word(BC);
        checks++;
        if (lock !== 1'b1 || err_cnt !== ERR1) begin
            errors++;
            $display("[TB] FAIL loss_first_miss: lock=%b err_cnt=%0d expected 1 and %0d",
                     lock, err_cnt, ERR1);
        end
        send_bit(1'b1);
        checks++;
        if (lock !== 1'b0 || valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL loss_drop: lock=%b valid=%b expected 0 and 0", lock, valid);
        end
        checks++;
        if (err_cnt !== ERR2) begin
            errors++;
            $display("[TB] FAIL loss_err: err_cnt=%0d expected %0d", err_cnt, ERR2);
        end
        vcount = 0;
        send_bits(BC, 7);
        send_word(BC);
        send_word(BC);
        checks++;
        if (vcount !== 0 || lock !== 1'b0) begin
            errors++;
            $display("[TB] FAIL loss_hunt: strobes=%0d lock=%b expected 0 and 0", vcount, lock);
        end
        send_bit(1'b0);
        checks++;
        if (lock !== 1'b1 || valid !== 1'b1 || out !== BC || out_DK !== 1'b1) begin
            errors++;
            $display("[TB] FAIL loss_relock: lock=%b valid=%b out=%h dk=%b expected 1 1 bc 1",
                     lock, valid, out, out_DK);
        end
        checks++;
        if (err_cnt !== ERR2) begin
            errors++;
            $display("[TB] FAIL loss_err_kept: err_cnt=%0d expected %0d", err_cnt, ERR2);
        end
    endtask

    task automatic test_miss_reset();
        do_reset();
        send_word(BC);
        send_word(BC);
        send_word(BC);
        send_word(D55);
        send_bits(8'h00, 3);
        send_word(BC);
        send_bits(8'h00, 5);
        send_word(BC);
        send_bits(8'h00, 3);
        checks++;
        if (last_out !== BC || last_dk !== 1'b1 || lock !== 1'b1) begin
            errors++;
            $display("[TB] FAIL miss_aligned: out=%h dk=%b lock=%b expected bc 1 1", last_out, last_dk, lock);
        end
        send_word(BC);
        send_bit(1'b0);
        checks++;
        if (lock !== 1'b1) begin
            errors++;
            $display("[TB] FAIL miss_cleared: lock=%b expected 1", lock);
        end
        checks++;
        if (err_cnt !== ERR2) begin
            errors++;
            $display("[TB] FAIL miss_err: err_cnt=%0d expected %0d", err_cnt, ERR2);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        send_word(BC);
        send_word(BC);
        send_word(BC);
        send_word(D55);
        send_bits(8'h00, 3);
        send_word(BC);
        send_bits(8'h00, 4);
        checks++;
        if (lock !== 1'b1 || err_cnt !== ERR1) begin
            errors++;
            $display("[TB] FAIL mid_pre: lock=%b err_cnt=%0d expected 1 and %0d", lock, err_cnt, ERR1);
        end
        #2;
        reset_L = 1'b0;
        #1;
        checks++;
        if (out !== 8'h00 || out_DK !== 1'b0 || valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mid_async_data: out=%h dk=%b valid=%b expected 00 0 0", out, out_DK, valid);
        end
        checks++;
        if (lock !== 1'b0 || err_cnt !== 8'h00) begin
            errors++;
            $display("[TB] FAIL mid_async_lock: lock=%b err_cnt=%0d expected 0 and 0", lock, err_cnt);
        end
        @(posedge clk);
        #1;
        reset_L = 1'b1;
        vcount  = 0;
        send_word(BC);
        send_word(BC);
        checks++;
        if (vcount !== 0 || lock !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mid_resume_early: strobes=%0d lock=%b expected 0 and 0", vcount, lock);
        end
        send_word(BC);
        send_bit(1'b0);
        checks++;
        if (lock !== 1'b1 || valid !== 1'b1 || out !== BC) begin
            errors++;
            $display("[TB] FAIL mid_resume_lock: lock=%b valid=%b out=%h expected 1 1 bc", lock, valid, out);
        end
    endtask

    initial begin
        $display("[TB] serdes_deser_align directed bench start");
        test_reset();
        test_lock();
        test_back_to_back();
        test_sync_fail();
        test_loss_of_lock();
        test_miss_reset();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
